// File: rtl/silencer_dual_step.sv
// silencer_dual_step: per-channel slew limiter for intensity and phase, one channel per clock.
// Latency: accept to dout_valid = DEPTH+4 edges; channel i is written on edge i+4 after accept.
// Backpressure: busy is high for the whole pass; din_valid is ignored except in the final pass cycle.
// Optional: define SILENCER_SETTLED_EN to add the registered all-channels-settled output.
module silencer_dual_step #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] step_intensity,
    input  logic [WIDTH-1:0] step_phase,
    input  logic [WIDTH-1:0] cycle       [DEPTH],
    input  logic [WIDTH-1:0] intensity   [DEPTH],
    input  logic [WIDTH-1:0] phase       [DEPTH],
    output logic [WIDTH-1:0] intensity_s [DEPTH],
    output logic [WIDTH-1:0] phase_s     [DEPTH],
    output logic             busy,
    output logic             dout_valid
`ifdef SILENCER_SETTLED_EN
    ,
    output logic             settled
`endif
);

    localparam int KW = $clog2(DEPTH + 4);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [KW-1:0] K_ISSUE = KW'(DEPTH);
    localparam logic [KW-1:0] K_LAST  = KW'(DEPTH + 3);

    typedef enum logic {IDLE, RUN} state_t;
    typedef logic signed [WIDTH:0] sw_t;

    state_t           state_q, state_d;
    logic             accept;
    logic             last;
    logic [KW-1:0]    k_q;
    logic             mode_q;
    logic [WIDTH-1:0] step_i_q, step_p_q;

    // Pass ends after the S4 slot of the last channel has drained.
    assign last = (state_q == RUN) && (k_q == K_LAST);
    assign busy = (state_q == RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and accept: a tick in the last RUN cycle starts the next pass with no gap.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    if (din_valid) accept  = 1'b1;
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pass counter, sampled configuration and end-of-pass pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            mode_q     <= 1'b0;
            step_i_q   <= '0;
            step_p_q   <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= last;
            if (accept) begin
                k_q      <= '0;
                mode_q   <= mode;
                step_i_q <= step_intensity;
                step_p_q <= step_phase;
            end else if (state_q == RUN) begin
                k_q <= k_q + KW'(1);
            end
        end
    end

    // ---------------- S1: read target, current and period ----------------
    logic             issue;
    logic [IW-1:0]    rd_idx;
    logic             p1_vld;
    logic [IW-1:0]    p1_idx;
    logic [WIDTH-1:0] p1_ti, p1_tp, p1_ci, p1_cp, p1_t;

    assign issue  = (state_q == RUN) && (k_q < K_ISSUE);
    assign rd_idx = k_q[IW-1:0];

    // Targets and period are sampled live, so mid-pass changes hit only unread channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_vld <= 1'b0;
            p1_idx <= '0;
            p1_ti  <= '0;
            p1_tp  <= '0;
            p1_ci  <= '0;
            p1_cp  <= '0;
            p1_t   <= '0;
        end else begin
            p1_vld <= issue;
            if (issue) begin
                p1_idx <= rd_idx;
                p1_ti  <= intensity[rd_idx];
                p1_tp  <= phase[rd_idx];
                p1_ci  <= intensity_s[rd_idx];
                p1_cp  <= phase_s[rd_idx];
                p1_t   <= cycle[rd_idx];
            end
        end
    end

    // ---------------- S2: differences and shortest phase path ----------------
    sw_t              s2_di, s2_dp_raw, s2_dp, s2_h, s2_t;
    logic [WIDTH-1:0] s2_tpf;

    // Phase difference is wrapped into [-h, +h]; d == +h stays positive so the tie goes forward.
    always_comb begin
        s2_t      = $signed({1'b0, p1_t});
        s2_h      = $signed({2'b00, p1_t[WIDTH-1:1]});
        s2_di     = $signed({1'b0, p1_ti}) - $signed({1'b0, p1_ci});
        s2_dp_raw = $signed({1'b0, p1_tp}) - $signed({1'b0, p1_cp});
        s2_dp     = s2_dp_raw;
        if (s2_dp_raw > s2_h)       s2_dp = s2_dp_raw - s2_t;
        else if (s2_dp_raw < -s2_h) s2_dp = s2_dp_raw + s2_t;
        s2_tpf = (p1_tp >= p1_t) ? (p1_tp - p1_t) : p1_tp;
    end

    logic             p2_vld;
    logic [IW-1:0]    p2_idx;
    logic [WIDTH-1:0] p2_ti, p2_tpf, p2_ci, p2_cp, p2_t;
    sw_t              p2_di, p2_dp;

    // S2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2_vld <= 1'b0;
            p2_idx <= '0;
            p2_ti  <= '0;
            p2_tpf <= '0;
            p2_ci  <= '0;
            p2_cp  <= '0;
            p2_t   <= '0;
            p2_di  <= '0;
            p2_dp  <= '0;
        end else begin
            p2_vld <= p1_vld;
            p2_idx <= p1_idx;
            p2_ti  <= p1_ti;
            p2_tpf <= s2_tpf;
            p2_ci  <= p1_ci;
            p2_cp  <= p1_cp;
            p2_t   <= p1_t;
            p2_di  <= s2_di;
            p2_dp  <= s2_dp;
        end
    end

    // ---------------- S3: clamp to step and add ----------------
    sw_t s3_si, s3_sp, s3_cdi, s3_cdp, s3_ni, s3_np;

    // Bypass loads the target directly; the phase target is already folded once in S2.
    always_comb begin
        s3_si  = $signed({1'b0, step_i_q});
        s3_sp  = $signed({1'b0, step_p_q});
        s3_cdi = p2_di;
        if (p2_di > s3_si)       s3_cdi = s3_si;
        else if (p2_di < -s3_si) s3_cdi = -s3_si;
        s3_cdp = p2_dp;
        if (p2_dp > s3_sp)       s3_cdp = s3_sp;
        else if (p2_dp < -s3_sp) s3_cdp = -s3_sp;
        if (mode_q) begin
            s3_ni = $signed({1'b0, p2_ti});
            s3_np = $signed({1'b0, p2_tpf});
        end else begin
            s3_ni = $signed({1'b0, p2_ci}) + s3_cdi;
            s3_np = $signed({1'b0, p2_cp}) + s3_cdp;
        end
    end

    logic             p3_vld;
    logic [IW-1:0]    p3_idx;
    logic [WIDTH-1:0] p3_ni;
    sw_t              p3_np;
    logic [WIDTH-1:0] p3_t;
`ifdef SILENCER_SETTLED_EN
    logic [WIDTH-1:0] p3_ti, p3_tpf;
`endif

    // S3 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p3_vld <= 1'b0;
            p3_idx <= '0;
            p3_ni  <= '0;
            p3_np  <= '0;
            p3_t   <= '0;
`ifdef SILENCER_SETTLED_EN
            p3_ti  <= '0;
            p3_tpf <= '0;
`endif
        end else begin
            p3_vld <= p2_vld;
            p3_idx <= p2_idx;
            p3_ni  <= s3_ni[WIDTH-1:0];
            p3_np  <= s3_np;
            p3_t   <= p2_t;
`ifdef SILENCER_SETTLED_EN
            p3_ti  <= p2_ti;
            p3_tpf <= p2_tpf;
`endif
        end
    end

    // ---------------- S4: fold phase into [0, T) and write back ----------------
    sw_t              s4_t, s4_fp;
    logic [WIDTH-1:0] wr_p;
    logic             unused_msb;

    // Slew result is folded once; this also pulls a phase back in range after T shrinks.
    always_comb begin
        s4_t  = $signed({1'b0, p3_t});
        s4_fp = p3_np;
        if (!mode_q) begin
            if (p3_np >= s4_t)     s4_fp = p3_np - s4_t;
            else if (p3_np < 0)    s4_fp = p3_np + s4_t;
        end
        wr_p = s4_fp[WIDTH-1:0];
    end

    assign unused_msb = ^{s4_fp[WIDTH], s3_ni[WIDTH]};

    // Current-value registers; only the channel leaving S4 is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < DEPTH; c++) begin
                intensity_s[c] <= '0;
                phase_s[c]     <= '0;
            end
        end else if (p3_vld) begin
            intensity_s[p3_idx] <= p3_ni;
            phase_s[p3_idx]     <= wr_p;
        end
    end

`ifdef SILENCER_SETTLED_EN
    logic flag_q;
    logic ch_ok;

    assign ch_ok = (p3_ni == p3_ti) && (wr_p == p3_tpf);

    // Flag starts true at accept and is ANDed per channel; published with dout_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q  <= 1'b0;
            settled <= 1'b0;
        end else begin
            if (last) settled <= flag_q;
            if (accept)      flag_q <= 1'b1;
            else if (p3_vld) flag_q <= flag_q & ch_ok;
        end
    end
`endif

endmodule

// File: tb/tb_silencer_dual_step.sv
// tb_silencer_dual_step: directed vector table plus handshake and reset-abort sequences.
// Latency: each pass is expected to produce dout_valid 8 edges after accept (DEPTH=4).
// Backpressure: ticks are only issued while busy is low, except in the handshake sequences.
module tb_silencer_dual_step;

    localparam int W = 13;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         din_valid;
    logic         mode;
    logic [W-1:0] step_intensity, step_phase;
    logic [W-1:0] cyc [D];
    logic [W-1:0] ti  [D];
    logic [W-1:0] tp  [D];
    logic [W-1:0] is_o[D];
    logic [W-1:0] ps_o[D];
    logic         busy, dout_valid;
`ifdef SILENCER_SETTLED_EN
    logic         settled;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    silencer_dual_step #(.WIDTH(W), .DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .din_valid      (din_valid),
        .mode           (mode),
        .step_intensity (step_intensity),
        .step_phase     (step_phase),
        .cycle          (cyc),
        .intensity      (ti),
        .phase          (tp),
        .intensity_s    (is_o),
        .phase_s        (ps_o),
        .busy           (busy),
        .dout_valid     (dout_valid)
`ifdef SILENCER_SETTLED_EN
        ,
        .settled        (settled)
`endif
    );

    typedef struct {
        int mode;
        int si;
        int sp;
        int t;
        int tgt_i;
        int tgt_p;
        int exp_i;
        int exp_p;
        int exp_set;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One tick from idle; checks accept and accept-to-dout_valid latency.
    task automatic do_pass(input string nm);
        int  n;
        bit  seen;
        @(negedge clk);
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        check({nm, "_busy"}, busy, 1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (dout_valid) seen = 1'b1;
        end
        check({nm, "_latency"}, n, 8);
    endtask

    initial begin
        int pos[8];
        int cnt;
        int waited;

        vecs[0]  = '{0,   16,   0, 100,   50,   0,   16,  0, 0};
        vecs[1]  = '{0,   16,   0, 100,   50,   0,   32,  0, 0};
        vecs[2]  = '{0,   16,   0, 100,   50,   0,   48,  0, 0};
        vecs[3]  = '{0,   16,   0, 100,   50,   0,   50,  0, 1};
        vecs[4]  = '{1,    0,   0, 100,   50,  95,   50, 95, 1};
        vecs[5]  = '{0,    0,   4, 100,  200,   5,   50, 99, 0};
        vecs[6]  = '{0, 8191,   4, 100, 8000,   5, 8000,  3, 0};
        vecs[7]  = '{0,    3,   4, 100, 7990,   5, 7997,  5, 0};
        vecs[8]  = '{0, 8191, 100, 100, 7990,   0, 7990,  0, 1};
        vecs[9]  = '{0,   16, 100, 100, 7990,  50, 7990, 50, 1};
        vecs[10] = '{0,   16, 100, 100, 7990,   0, 7990,  0, 1};
        vecs[11] = '{0,   16,  10, 100, 7990,  50, 7990, 10, 0};
        vecs[12] = '{0,   16, 100, 100, 7990,  10, 7990, 10, 1};
        vecs[13] = '{0,   16,  30, 100, 7990,  80, 7990, 80, 1};
        vecs[14] = '{0,   16,   0, 100, 7990,  20, 7990, 80, 0};
        vecs[15] = '{1,    0,   0, 100,  123, 120,  123, 20, 1};
        vecs[16] = '{1,    0,   0, 100,  123,  90,  123, 90, 1};
        vecs[17] = '{0,    0,   5,  50,  123,  10,  123, 35, 0};

        rst_n          = 1'b0;
        din_valid      = 1'b0;
        mode           = 1'b0;
        step_intensity = '0;
        step_phase     = '0;
        for (int c = 0; c < D; c++) begin
            cyc[c] = W'(100);
            ti[c]  = '0;
            tp[c]  = '0;
        end

        // Reset state.
        #1;
        for (int c = 0; c < D; c++) begin
            check($sformatf("rst_int%0d", c), is_o[c], 0);
            check($sformatf("rst_ph%0d", c), ps_o[c], 0);
        end
        check("rst_busy", busy, 0);
        check("rst_dout", dout_valid, 0);
`ifdef SILENCER_SETTLED_EN
        check("rst_settled", settled, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: one pass per entry, targets identical across channels.
        for (int v = 0; v < 18; v++) begin
            @(negedge clk);
            mode           = vecs[v].mode[0];
            step_intensity = W'(vecs[v].si);
            step_phase     = W'(vecs[v].sp);
            for (int c = 0; c < D; c++) begin
                cyc[c] = W'(vecs[v].t);
                ti[c]  = W'(vecs[v].tgt_i);
                tp[c]  = W'(vecs[v].tgt_p);
            end
            do_pass($sformatf("v%0d", v));
            for (int c = 0; c < D; c++) begin
                check($sformatf("v%0d_int%0d", v, c), is_o[c], vecs[v].exp_i);
                check($sformatf("v%0d_ph%0d", v, c), ps_o[c], vecs[v].exp_p);
            end
`ifdef SILENCER_SETTLED_EN
            check($sformatf("v%0d_settled", v), settled, vecs[v].exp_set);
`endif
        end

        // Distinct per-channel targets in bypass, including one that needs folding.
        @(negedge clk);
        mode = 1'b1;
        for (int c = 0; c < D; c++) begin
            cyc[c] = W'(100);
            ti[c]  = W'(10 * c + 1);
            tp[c]  = W'(40 * c + 5);
        end
        do_pass("chan");
        for (int c = 0; c < D; c++) begin
            check($sformatf("chan_int%0d", c), is_o[c], 10 * c + 1);
            check($sformatf("chan_ph%0d", c), ps_o[c], (40 * c + 5) % 100);
        end

        // din_valid held high: back-to-back passes every 8 edges.
        @(negedge clk);
        din_valid = 1'b1;
        cnt = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (dout_valid) begin
                if (cnt < 8) pos[cnt] = e;
                cnt++;
            end
        end
        din_valid = 1'b0;
        check("hold_count", cnt, 4);
        for (int i = 0; i < 4; i++) check($sformatf("hold_pos%0d", i), pos[i], 9 + 8 * i);
        waited = 0;
        while (busy && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("hold_drain", busy, 0);

        // A tick mid-RUN is dropped: exactly one dout_valid.
        @(negedge clk);
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        cnt = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (dout_valid) cnt++;
        end
        check("midrun_count", cnt, 1);
        check("midrun_busy", busy, 0);

        // Reset asserted at RUN cycle 2 aborts the pass.
        @(negedge clk);
        mode = 1'b1;
        for (int c = 0; c < D; c++) begin
            ti[c] = W'(123);
            tp[c] = W'(120);
        end
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < D; c++) begin
            check($sformatf("abort_int%0d", c), is_o[c], 0);
            check($sformatf("abort_ph%0d", c), ps_o[c], 0);
        end
        check("abort_busy", busy, 0);
        check("abort_dout", dout_valid, 0);
`ifdef SILENCER_SETTLED_EN
        check("abort_settled", settled, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (dout_valid) cnt++;
        end
        check("abort_no_dout", cnt, 0);
        check("abort_int0_after", is_o[0], 0);
        check("abort_busy_after", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
